dtc_vote_accumulator: RTL and testbench

- Downstream consumer of a dtc_* decision-tree classifier stage.
- Takes that stage's 2-bit per-sample class prediction as a valid/ready stream and builds a per-class vote histogram over a window of WINDOW samples.
- At the end of each window it emits the majority class, its vote count, a tie flag and the sample count.
- Converts noisy per-sample decisions into one stable decision per window for the system controller.

---
 rtl/dtc_pkg.sv | 20 ++
 rtl/dtc_argmax4.sv | 56 +++++
 rtl/dtc_vote_accumulator.sv | 145 ++++++++++++++
 tb/tb_dtc_vote_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtc_pkg
// Description : Shared constants and types for the dtc_* classifier voters.
// Revision    : 1.0 - initial release
// ============================================================================
package dtc_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int CLASS_W     = 2;

  // Window accumulator control states
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dtc_argmax4.sv
`default_nettype none
// ============================================================================
// Module      : dtc_argmax4
// Description : Combinational argmax over four class vote counts. Ties are
//               broken towards the lowest class index; o_tie reports that at
//               least one other class shares the maximum count.
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_argmax4
  import dtc_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0]   i_cnt0,
  input  logic [CNT_W-1:0]   i_cnt1,
  input  logic [CNT_W-1:0]   i_cnt2,
  input  logic [CNT_W-1:0]   i_cnt3,
  output logic [CLASS_W-1:0] o_idx,
  output logic [CNT_W-1:0]   o_max,
  output logic               o_tie
);

  logic [CLASS_W-1:0]     w_idx;
  logic [CNT_W-1:0]       w_max;
  logic [NUM_CLASSES-1:0] w_eq;

  // Strict greater-than keeps the earliest (lowest) index on equal counts
  always_comb begin
    w_idx = CLASS_W'(0);
    w_max = i_cnt0;
    if (i_cnt1 > w_max) begin
      w_idx = CLASS_W'(1);
      w_max = i_cnt1;
    end
    if (i_cnt2 > w_max) begin
      w_idx = CLASS_W'(2);
      w_max = i_cnt2;
    end
    if (i_cnt3 > w_max) begin
      w_idx = CLASS_W'(3);
      w_max = i_cnt3;
    end
  end

  assign w_eq[0] = (i_cnt0 == w_max);
  assign w_eq[1] = (i_cnt1 == w_max);
  assign w_eq[2] = (i_cnt2 == w_max);
  assign w_eq[3] = (i_cnt3 == w_max);

  assign o_idx = w_idx;
  assign o_max = w_max;
  // More than one bit set in w_eq means another class matches the winner
  assign o_tie = |(w_eq & (w_eq - NUM_CLASSES'(1)));

endmodule
`default_nettype wire

// File: rtl/dtc_vote_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dtc_vote_accumulator
// Description : Collects per-sample class predictions into a per-class vote
//               histogram over a window of WINDOW samples (or fewer when
//               flushed) and emits the majority class, its vote count, the
//               sample count and a tie flag once per window.
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_vote_accumulator
  import dtc_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CLASS_W-1:0]   inp,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CLASS_W-1:0]   outp,
  output logic [CNT_W-1:0]     out_count,
  output logic [CNT_W-1:0]     out_samples,
  output logic                 out_tie
);

  state_t               r_state;
  state_t               w_state_next;

  logic [CNT_W-1:0]     r_cnt [NUM_CLASSES];
  logic [CNT_W-1:0]     r_samples;
  logic [CNT_W-1:0]     w_samples_next;

  logic                 w_accept;
  logic                 w_close;
  logic                 w_release;

  logic [CLASS_W-1:0]   w_arg_idx;
  logic [CNT_W-1:0]     w_arg_max;
  logic                 w_arg_tie;

  logic [CLASS_W-1:0]   r_outp;
  logic [CNT_W-1:0]     r_out_count;
  logic [CNT_W-1:0]     r_out_samples;
  logic                 r_out_tie;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == EMIT);

  assign w_accept       = in_valid && in_ready;
  assign w_samples_next = r_samples + CNT_W'(w_accept);
  assign w_release      = out_valid && out_ready;

  // A window closes when it fills, or on flush once it holds at least one
  // sample (counting a sample accepted in the same cycle as the flush).
  assign w_close = (w_accept && (w_samples_next == CNT_W'(WINDOW))) ||
                   (flush && (w_samples_next != '0));

  dtc_argmax4 #(
    .CNT_W (CNT_W)
  ) u_argmax (
    .i_cnt0 (r_cnt[0]),
    .i_cnt1 (r_cnt[1]),
    .i_cnt2 (r_cnt[2]),
    .i_cnt3 (r_cnt[3]),
    .o_idx  (w_arg_idx),
    .o_max  (w_arg_max),
    .o_tie  (w_arg_tie)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: ACCUM -> RESOLVE (one cycle) -> EMIT -> ACCUM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: begin
        if (w_close) begin
          w_state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        w_state_next = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          w_state_next = ACCUM;
        end
      end
      default: begin
        w_state_next = ACCUM;
      end
    endcase
  end

  // Vote histogram and sample counter; cleared when the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_cnt[i] <= '0;
      end
      r_samples <= '0;
    end else if (w_release) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_cnt[i] <= '0;
      end
      r_samples <= '0;
    end else if (w_accept) begin
      r_cnt[inp] <= r_cnt[inp] + CNT_W'(1);
      r_samples  <= w_samples_next;
    end
  end

  // Capture the window result during RESOLVE; held until the next window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outp        <= '0;
      r_out_count   <= '0;
      r_out_samples <= '0;
      r_out_tie     <= 1'b0;
    end else if (r_state == RESOLVE) begin
      r_outp        <= w_arg_idx;
      r_out_count   <= w_arg_max;
      r_out_samples <= r_samples;
      r_out_tie     <= w_arg_tie;
    end
  end

  assign outp        = r_outp;
  assign out_count   = r_out_count;
  assign out_samples = r_out_samples;
  assign out_tie     = r_out_tie;

endmodule
`default_nettype wire

// File: tb/tb_dtc_vote_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc_vote_accumulator
// Description : Directed self-checking bench for dtc_vote_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc_vote_accumulator;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       inp;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       outp;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_samples;
  logic             out_tie;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dtc_vote_accumulator #(
    .WINDOW (WINDOW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inp         (inp),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .outp        (outp),
    .out_count   (out_count),
    .out_samples (out_samples),
    .out_tie     (out_tie)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Move to the next falling edge and present new inputs for the next rise.
  // Outputs seen right after this reflect the previous rising edge.
  task automatic step(input logic v, input logic [1:0] c, input logic f);
    @(negedge clk);
    in_valid = v;
    inp      = c;
    flush    = f;
  endtask

  task automatic feed(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, c, 1'b0);
      check("feed_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  // Called right after the step carrying the last sample or the flush
  task automatic expect_window(input string tag, input int cls, input int cnt,
                               input int samp, input int tie);
    step(1'b0, 2'd0, 1'b0);
    check({tag, "_resolve_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_resolve_ready"}, 32'(in_ready), 32'd0);
    step(1'b0, 2'd0, 1'b0);
    check({tag, "_valid"},   32'(out_valid),   32'd1);
    check({tag, "_outp"},    32'(outp),        32'(cls));
    check({tag, "_count"},   32'(out_count),   32'(cnt));
    check({tag, "_samples"}, 32'(out_samples), 32'(samp));
    check({tag, "_tie"},     32'(out_tie),     32'(tie));
    step(1'b0, 2'd0, 1'b0);
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_back_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inp       = 2'd0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_ready",   32'(in_ready),    32'd1);
    check("rst_outp",    32'(outp),        32'd0);
    check("rst_count",   32'(out_count),   32'd0);
    check("rst_samples", 32'(out_samples), 32'd0);
    check("rst_tie",     32'(out_tie),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform window of class 2
    feed(2'd2, 16);
    expect_window("uni2", 2, 16, 16, 0);

    // Interleaved 5x0, 5x1, 6x3
    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       step(1'b1, 2'd0, 1'b0);
        1:       step(1'b1, 2'd1, 1'b0);
        default: step(1'b1, 2'd3, 1'b0);
      endcase
      if (i == 15) inp = 2'd3;
    end
    expect_window("mix3", 3, 6, 16, 0);

    // 8x1 and 8x3 alternating: tie resolved to class 1
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'd1 : 2'd3, 1'b0);
    end
    expect_window("tie13", 1, 8, 16, 1);

    // Back-pressure: result held while in_valid stays high
    out_ready = 1'b0;
    feed(2'd0, 16);
    step(1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd1, 1'b0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready),  32'd0);
      check("stall_outp",  32'(outp),      32'd0);
      check("stall_count", 32'(out_count), 32'd16);
      check("stall_samp",  32'(out_samples), 32'd16);
    end
    step(1'b0, 2'd0, 1'b0);
    out_ready = 1'b1;
    check("stall_last_valid", 32'(out_valid), 32'd1);
    step(1'b0, 2'd0, 1'b0);
    check("stall_release", 32'(out_valid), 32'd0);
    feed(2'd2, 4);
    step(1'b0, 2'd0, 1'b1);
    expect_window("after_stall", 2, 4, 4, 0);

    // Flush after {0,0,2}
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    expect_window("flush3", 0, 2, 3, 0);

    // Flush on an empty window is ignored
    step(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0);
      check("empty_flush_valid", 32'(out_valid), 32'd0);
      check("empty_flush_ready", 32'(in_ready),  32'd1);
    end

    // Flush together with the first accepted sample
    step(1'b1, 2'd3, 1'b1);
    expect_window("flush1", 3, 1, 1, 0);

    // Asynchronous reset mid-window
    feed(2'd2, 7);
    step(1'b0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    feed(2'd1, 16);
    expect_window("post_rst_mid", 1, 16, 16, 0);

    // Asynchronous reset during EMIT
    out_ready = 1'b0;
    feed(2'd1, 16);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    check("pre_rst_emit_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_emit_valid", 32'(out_valid), 32'd0);
    check("rst_emit_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0);
      check("no_partial_valid", 32'(out_valid), 32'd0);
    end
    feed(2'd1, 16);
    expect_window("post_rst_emit", 1, 16, 16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
